// File: rtl/immediate_pkg.sv
// Shared types and elaboration helpers for the immediate generator and its
// reusable extender core.
package immediate_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_NONE  = 3'b111
  } imm_src_t;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic int shamt_w(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/immediate_extender_core.sv
// Combinational RV32I/RV64I immediate extraction and extension; shared with
// the branch unit, so it carries no state and no handshake.
module immediate_extender_core
  import immediate_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] immediate
);

  localparam int SW = shamt_w(XLEN);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("immediate_extender_core: XLEN must be 32 or 64");
  end

  // Signed formats are cast through $signed so the size cast replicates instr[31].
  always_comb begin
    immediate = '0;
    unique case (imm_src)
      IMM_I: immediate = XLEN'($signed(instruction[31:20]));
      IMM_S: immediate = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      IMM_B: immediate = XLEN'($signed({instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0}));
      IMM_U: immediate = XLEN'($signed({instruction[31:12], 12'b0}));
      IMM_J: immediate = XLEN'($signed({instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0}));
      IMM_SHAMT: immediate[SW-1:0] = instruction[20 +: SW];
      IMM_ZIMM:  immediate[4:0]    = instruction[19:15];
      default:   immediate = '0;
    endcase
  end

endmodule

// File: rtl/immediate_generator_stage.sv
// Registered immediate generator: extends at the input and carries the result
// plus a sideband tag through a 2-entry skid FIFO with valid/ready on both sides.
module immediate_generator_stage
  import immediate_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_ig,
  input  logic             rst_ig,
  input  logic             flush_ig,
  input  logic             in_valid_ig,
  output logic             in_ready_ig,
  input  logic [31:0]      instruction_ig,
  input  logic [2:0]       imm_src_ig,
  input  logic [TAG_W-1:0] tag_in_ig,
  output logic             out_valid_ig,
  input  logic             out_ready_ig,
  output logic [XLEN-1:0]  immediate_ig,
  output logic [TAG_W-1:0] tag_out_ig
);

  logic [XLEN-1:0]  imm_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [XLEN-1:0]  imm_new;
  logic             push;
  logic             pop;

  immediate_extender_core #(.XLEN(XLEN)) u_core (
    .instruction (instruction_ig),
    .imm_src     (imm_src_t'(imm_src_ig)),
    .immediate   (imm_new)
  );

  // in_ready looks only at count so out_ready never reaches it combinationally.
  assign in_ready_ig  = (count < 2'd2) && !rst_ig;
  assign out_valid_ig = (count != 2'd0);
  assign push         = in_valid_ig && in_ready_ig && !flush_ig;
  assign pop          = out_valid_ig && out_ready_ig && !flush_ig;

  assign immediate_ig = imm_mem[head];
  assign tag_out_ig   = tag_mem[head];

  always_ff @(posedge clk_ig) begin
    if (rst_ig) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
    end else if (flush_ig) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        imm_mem[tail] <= imm_new;
        tag_mem[tail] <= tag_in_ig;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_immediate_generator_stage.sv
// Randomised and directed bench: two stage instances (XLEN 32 and 64) share
// stimulus and are compared against a queue-based model of the FIFO.
module tb_immediate_generator_stage;

  logic        clk_ig = 1'b0;
  logic        rst_ig = 1'b1;
  logic        flush_ig = 1'b0;
  logic        in_valid_ig = 1'b0;
  logic [31:0] instruction_ig = '0;
  logic [2:0]  imm_src_ig = '0;
  logic [31:0] tag_in_ig = '0;
  logic        out_ready_ig = 1'b0;

  logic        in_ready_32, out_valid_32, in_ready_64, out_valid_64;
  logic [31:0] imm_32, tag_32, tag_64;
  logic [63:0] imm_64;

  always #5 clk_ig = ~clk_ig;

  immediate_generator_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_ig (clk_ig), .rst_ig (rst_ig), .flush_ig (flush_ig),
    .in_valid_ig (in_valid_ig), .in_ready_ig (in_ready_32),
    .instruction_ig (instruction_ig), .imm_src_ig (imm_src_ig),
    .tag_in_ig (tag_in_ig), .out_valid_ig (out_valid_32),
    .out_ready_ig (out_ready_ig), .immediate_ig (imm_32), .tag_out_ig (tag_32)
  );

  immediate_generator_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_ig (clk_ig), .rst_ig (rst_ig), .flush_ig (flush_ig),
    .in_valid_ig (in_valid_ig), .in_ready_ig (in_ready_64),
    .instruction_ig (instruction_ig), .imm_src_ig (imm_src_ig),
    .tag_in_ig (tag_in_ig), .out_valid_ig (out_valid_64),
    .out_ready_ig (out_ready_ig), .immediate_ig (imm_64), .tag_out_ig (tag_64)
  );

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  bit   zeroed;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Field value interpreted as a two's-complement number of 'bits' width.
  function automatic logic [63:0] sx(input logic [63:0] f, input int bits);
    if (f >= (64'd1 << (bits - 1))) return f - (64'd1 << bits);
    return f;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int src, input int xlen);
    logic [63:0] w, f, v;
    w = {32'b0, ins};
    case (src)
      0: v = sx((w >> 20) & 64'hFFF, 12);
      1: v = sx((((w >> 25) & 64'h7F) << 5) + ((w >> 7) & 64'h1F), 12);
      2: begin
        f = (((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11)
          + (((w >> 25) & 64'h3F) << 5) + (((w >> 8) & 64'hF) << 1);
        v = sx(f, 13);
      end
      3: v = sx(w & 64'hFFFF_F000, 32);
      4: begin
        f = (((w >> 31) & 1) << 20) + (((w >> 12) & 64'hFF) << 12)
          + (((w >> 20) & 1) << 11) + (((w >> 21) & 64'h3FF) << 1);
        v = sx(f, 21);
      end
      5: v = (w >> 20) & ((xlen == 64) ? 64'd63 : 64'd31);
      6: v = (w >> 15) & 64'd31;
      default: v = 64'd0;
    endcase
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  task automatic check_out();
    chk("out_valid32", {63'b0, out_valid_32}, {63'b0, q.size() != 0});
    chk("out_valid64", {63'b0, out_valid_64}, {63'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("imm32", {32'b0, imm_32}, q[0].i32);
      chk("imm64", imm_64, q[0].i64);
      chk("tag32", {32'b0, tag_32}, {32'b0, q[0].tag});
      chk("tag64", {32'b0, tag_64}, {32'b0, q[0].tag});
    end else if (zeroed) begin
      chk("rst_imm32", {32'b0, imm_32}, 64'd0);
      chk("rst_imm64", imm_64, 64'd0);
      chk("rst_tag32", {32'b0, tag_32}, 64'd0);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance the model, then check outputs.
  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] s,
                      input logic [31:0] t, input bit ordy, input bit fl, input bit r);
    bit   do_push, do_pop;
    ent_t e;
    in_valid_ig = v; instruction_ig = ins; imm_src_ig = s; tag_in_ig = t;
    out_ready_ig = ordy; flush_ig = fl; rst_ig = r;
    #1;
    chk("in_ready32", {63'b0, in_ready_32}, {63'b0, !r && q.size() < 2});
    chk("in_ready64", {63'b0, in_ready_64}, {63'b0, !r && q.size() < 2});
    if (r) begin
      q.delete();
      zeroed = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = (q.size() > 0) && ordy;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.i32 = ref_imm(ins, int'(s), 32);
        e.i64 = ref_imm(ins, int'(s), 64);
        e.tag = t;
        q.push_back(e);
        zeroed = 1'b0;
      end
    end
    @(posedge clk_ig);
    @(negedge clk_ig);
    check_out();
  endtask

  initial begin
    zeroed = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Known vectors, out_ready held high.
    step(1, 32'hFFF00093, 3'd0, 32'h10, 1, 0, 0); chk("vec_I",    {32'b0, imm_32}, 64'hFFFFFFFF);
    step(1, 32'hFE000EE3, 3'd2, 32'h11, 1, 0, 0); chk("vec_B",    {32'b0, imm_32}, 64'hFFFFFFFC);
    step(1, 32'h123450B7, 3'd3, 32'h12, 1, 0, 0); chk("vec_U",    {32'b0, imm_32}, 64'h12345000);
    step(1, 32'h008000EF, 3'd4, 32'h13, 1, 0, 0); chk("vec_J",    {32'b0, imm_32}, 64'h00000008);
    step(1, 32'h0002D073, 3'd6, 32'h14, 1, 0, 0); chk("vec_ZIMM", {32'b0, imm_32}, 64'h00000005);
    step(1, 32'h800000B7, 3'd3, 32'h15, 1, 0, 0); chk("vec_U64",  imm_64, 64'hFFFFFFFF80000000);
    step(1, 32'h03F0D093, 3'd5, 32'h16, 1, 0, 0); chk("vec_SH64", imm_64, 64'h000000000000003F);
    chk("vec_SH32", {32'b0, imm_32}, 64'h1F);
    step(0, 0, 0, 0, 1, 0, 0);

    // Backpressure: tag 3 must be held off until the buffer drains.
    step(1, 32'hFFF00093, 3'd0, 32'd1, 0, 0, 0);
    step(1, 32'h123450B7, 3'd3, 32'd2, 0, 0, 0);
    step(1, 32'h008000EF, 3'd4, 32'd3, 0, 0, 0);
    chk("bp_head", {32'b0, tag_32}, 64'd1);
    step(1, 32'h008000EF, 3'd4, 32'd3, 1, 0, 0);
    chk("bp_second", {32'b0, tag_32}, 64'd2);
    step(1, 32'h008000EF, 3'd4, 32'd3, 1, 0, 0);
    chk("bp_third", {32'b0, tag_32}, 64'd3);
    step(0, 0, 0, 0, 1, 0, 0);

    // Simultaneous push and pop at count 1.
    step(1, $urandom, 3'($urandom_range(7)), 32'h100, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom, 3'($urandom_range(7)), 32'h101 + i, 1, 0, 0);
      chk("pp_valid", {63'b0, out_valid_32}, 64'd1);
      chk("pp_tag", {32'b0, tag_32}, 64'h101 + i);
    end
    step(0, 0, 0, 0, 1, 0, 0);

    // Flush with the buffer full and a push offered.
    step(1, 32'hFFF00093, 3'd0, 32'h21, 0, 0, 0);
    step(1, 32'hFFF00093, 3'd0, 32'h22, 0, 0, 0);
    step(1, 32'hFFF00093, 3'd0, 32'hDEAD, 1, 1, 0);
    chk("fl_valid", {63'b0, out_valid_32}, 64'd0);
    chk("fl_ready", {63'b0, in_ready_32}, 64'd1);
    step(0, 0, 0, 0, 1, 0, 0);

    // Reset with two entries buffered.
    step(1, 32'hFFF00093, 3'd0, 32'h31, 0, 0, 0);
    step(1, 32'h800000B7, 3'd3, 32'h32, 0, 0, 0);
    step(1, 32'h800000B7, 3'd3, 32'h33, 1, 0, 1);
    chk("rst_valid", {63'b0, out_valid_32}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, $urandom, 3'($urandom_range(7)), $urandom,
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 150) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/immediate_generator_stage.md
# immediate_generator_stage

Registered, parametrised immediate generator for the decode/execute boundary of the pipelined RV core. It extracts and extends the immediate for every RV32I/RV64I format, plus shift amounts and the CSR zimm field. The result travels with a caller-supplied tag (PC or ROB index) through a 2-entry skid buffer with valid/ready handshakes on both sides, so decode stalls and flushes never corrupt an in-flight immediate.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 and 64 only, elaboration error otherwise.
- TAG_W, 32: width of the sideband tag carried alongside each immediate.

Ports:
- clk_ig  input  1  single clock; all state updates on rising edge.
- rst_ig  input  1  reset, synchronous, active-high.
- flush_ig  input  1  discard all buffered entries this cycle.
- in_valid_ig  input  1  instruction/src/tag valid.
- in_ready_ig  output  1  stage can accept an entry this cycle.
- instruction_ig  input  32  raw instruction word.
- imm_src_ig  input  3  format select; encoding in Operation.
- tag_in_ig  input  TAG_W  sideband, passed through unchanged.
- out_valid_ig  output  1  head entry valid.
- out_ready_ig  input  1  consumer accepts head entry.
- immediate_ig  output  XLEN  extended immediate of head entry.
- tag_out_ig  output  TAG_W  tag of head entry.

## Operation
- imm_src encoding:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 U: sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 are copies of instr[31].
  - 100 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 101 SHAMT: zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - 110 ZIMM: zero-extended instr[19:15].
  - 111: all zeros.
- sext means sign-extend to XLEN from the field MSB (instr[31] in every signed format).
- The immediate is computed combinationally at the input and stored already extended. The raw instruction is not buffered.
- Buffer: 2-entry FIFO (head/tail pointers plus a count of 0..2).
  - in_ready_ig = (count < 2) && !rst_ig.
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
- Count transitions:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged. This is legal at count 1. At count 0, pop is impossible. At count 2, push is impossible.
- Output: out_valid = (count != 0). immediate/tag always show the head entry. They hold their value while out_valid is high and out_ready is low.
- Flush: count, head and tail go to 0 at the next edge. A simultaneous push is dropped and a simultaneous pop is not counted as a transfer. Buffer storage contents are don't-care.

## Timing
- Latency: an entry accepted at edge N is visible on the output at edge N (registered), i.e. out_valid is high in the cycle after acceptance. There is no combinational path from in_* to out_*.
- in_ready depends only on count and reset, not on out_ready. This means no combinational path from out_ready to in_ready. The consequence is one bubble of throughput loss when the buffer is full and drains; full throughput holds at count ≤ 1.
- Order is strictly FIFO. There is no drop or duplication except on flush or reset.
- Reset (synchronous, takes priority over flush and all handshakes):
  - count, head and tail = 0, so out_valid_ig = 0.
  - immediate_ig = 0 and tag_out_ig = 0 (storage cleared).
  - in_ready_ig = 0 while rst_ig is high, 1 in the first cycle after release.
- Reset mid-operation discards all entries exactly like a flush and additionally zeroes storage.

## Structure
- Package immediate_pkg:
  - imm_src_t enum with the eight encodings above.
  - XLEN legality check constant/function.
  - SHAMT width function (5 for 32, 6 for 64).
- Sub-module immediate_extender_core: purely combinational, parametrised by XLEN, instruction + imm_src_t → XLEN immediate. It is reused by the branch unit.
- Top contains only the skid FIFO, handshake logic and the core instance.

## Test plan
- XLEN=32, one push per imm_src, out_ready=1:
  - 0xFFF00093/I → 0xFFFFFFFF.
  - 0xFE000EE3/B → 0xFFFFFFFC.
  - 0x123450B7/U → 0x12345000.
  - 0x008000EF/J → 0x00000008.
  - 0x0002D073/ZIMM → 0x00000005.
- XLEN=64: 0x800000B7/U → 0xFFFFFFFF80000000. 0x03F0D093 (shamt 63)/SHAMT → 0x000000000000003F.
- Backpressure: out_ready=0, offer tags 1,2,3 on consecutive cycles → in_ready drops after tag 2 and tag 3 is held. Raising out_ready then yields tags 1,2,3 in order with matching immediates and no duplicates.
- Simultaneous push+pop at count 1 for 10 cycles → count stays 1, out_valid stays high, one transfer per cycle.
- Flush with count 2 and in_valid high → next cycle out_valid=0, in_ready=1, and the flushed input's tag never appears.
- Assert rst_ig for one cycle with count 2 → out_valid=0, immediate=0, tag_out=0 next cycle. in_ready is 0 during reset and 1 the cycle after release.
